// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use interlock unit.
// Resolves NSRC operands from XM/MW bypasses, holds forwarded values across stalls, counts hazard stalls.
module fwd_hazard_unit #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int NSRC   = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic                     ext_stall,
    input  logic                     flush,
    input  logic [NSRC-1:0]          src_req,
    input  logic [NSRC*REG_W-1:0]    src_reg,
    input  logic [NSRC*DATA_W-1:0]   src_data,
    input  logic                     xm_valid,
    input  logic                     xm_wr_en,
    input  logic                     xm_mem_read,
    input  logic [REG_W-1:0]         xm_rd,
    input  logic [DATA_W-1:0]        xm_data,
    input  logic                     mw_valid,
    input  logic                     mw_wr_en,
    input  logic [REG_W-1:0]         mw_rd,
    input  logic [DATA_W-1:0]        mw_data,
    output logic [NSRC*DATA_W-1:0]   fwd_data,
    output logic [NSRC*2-1:0]        fwd_sel,
    output logic                     stall_ex,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_XM  = 2'd1;
    localparam logic [1:0] SEL_MW  = 2'd2;
    localparam logic [1:0] SEL_CAP = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NSRC-1:0]             xm_hit;
    logic [NSRC-1:0]             mw_hit;
    logic [NSRC-1:0]             load_use;
    logic                        raw_stall;
    logic                        hold;
    logic                        advance;
    logic                        cap_clear;

    logic [NSRC-1:0]             cap_valid_q, cap_valid_d;
    logic [NSRC-1:0][DATA_W-1:0] cap_data_q, cap_data_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    always_comb begin
        xm_hit   = '0;
        mw_hit   = '0;
        load_use = '0;
        for (int i = 0; i < NSRC; i++) begin
            xm_hit[i] = src_req[i] & ex_valid & xm_valid & xm_wr_en
                        & (src_reg[i*REG_W +: REG_W] == xm_rd);
            mw_hit[i] = src_req[i] & ex_valid & mw_valid & mw_wr_en
                        & (src_reg[i*REG_W +: REG_W] == mw_rd);
            // A captured operand already holds the right value, so it no longer needs to wait on the load.
            load_use[i] = xm_hit[i] & xm_mem_read & ~cap_valid_q[i];
        end
    end

    always_comb begin
        if (FWD_EN != 0) begin
            raw_stall = |load_use;
        end else begin
            raw_stall = |(xm_hit | mw_hit);
        end
        stall_ex = raw_stall & ~flush;
    end

    always_comb begin
        fwd_data = src_data;
        fwd_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            fwd_sel[i*2 +: 2] = SEL_RF;
            if (FWD_EN != 0) begin
                if (cap_valid_q[i]) begin
                    fwd_sel[i*2 +: 2]           = SEL_CAP;
                    fwd_data[i*DATA_W +: DATA_W] = cap_data_q[i];
                end else if (xm_hit[i] && !xm_mem_read) begin
                    fwd_sel[i*2 +: 2]           = SEL_XM;
                    fwd_data[i*DATA_W +: DATA_W] = xm_data;
                end else if (mw_hit[i]) begin
                    fwd_sel[i*2 +: 2]           = SEL_MW;
                    fwd_data[i*DATA_W +: DATA_W] = mw_data;
                end
            end
        end
    end

    assign hold      = ex_valid & (stall_ex | ext_stall) & ~flush;
    assign advance   = ex_valid & ~stall_ex & ~ext_stall;
    assign cap_clear = advance | flush | ~ex_valid;

    // First capture wins: later hits during a hold come from older producers.
    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_data_d  = cap_data_q;
        if (cap_clear) begin
            cap_valid_d = '0;
        end else if (hold && (FWD_EN != 0)) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!cap_valid_q[i] &&
                    ((fwd_sel[i*2 +: 2] == SEL_XM) || (fwd_sel[i*2 +: 2] == SEL_MW))) begin
                    cap_valid_d[i] = 1'b1;
                    cap_data_d[i]  = fwd_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_ex && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid_q <= '0;
            cap_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: bypass and interlock instances driven from shared stimulus,
// checked against constant vectors, directed sequences and a reference model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ext_stall, flush;
    logic [2:0]  src_req;
    logic [8:0]  src_reg;
    logic [47:0] src_data;
    logic        xm_valid, xm_wr_en, xm_mem_read;
    logic [2:0]  xm_rd;
    logic [15:0] xm_data;
    logic        mw_valid, mw_wr_en;
    logic [2:0]  mw_rd;
    logic [15:0] mw_data;

    logic [47:0] fd1, fd0;
    logic [5:0]  fs1, fs0;
    logic        st1, st0;
    logic [15:0] sc1, sc0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DATA_W(16), .REG_W(3), .NSRC(3), .FWD_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ext_stall(ext_stall), .flush(flush),
        .src_req(src_req), .src_reg(src_reg), .src_data(src_data),
        .xm_valid(xm_valid), .xm_wr_en(xm_wr_en), .xm_mem_read(xm_mem_read),
        .xm_rd(xm_rd), .xm_data(xm_data),
        .mw_valid(mw_valid), .mw_wr_en(mw_wr_en), .mw_rd(mw_rd), .mw_data(mw_data),
        .fwd_data(fd1), .fwd_sel(fs1), .stall_ex(st1), .stall_cnt(sc1)
    );

    fwd_hazard_unit #(.DATA_W(16), .REG_W(3), .NSRC(3), .FWD_EN(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ext_stall(ext_stall), .flush(flush),
        .src_req(src_req), .src_reg(src_reg), .src_data(src_data),
        .xm_valid(xm_valid), .xm_wr_en(xm_wr_en), .xm_mem_read(xm_mem_read),
        .xm_rd(xm_rd), .xm_data(xm_data),
        .mw_valid(mw_valid), .mw_wr_en(mw_wr_en), .mw_rd(mw_rd), .mw_data(mw_data),
        .fwd_data(fd0), .fwd_sel(fs0), .stall_ex(st0), .stall_cnt(sc0)
    );

    // Reference model state: captured operands (bypass instance) and stall counts.
    logic        m_cap_v [3];
    logic [15:0] m_cap_d [3];
    int          m_cnt1, m_cnt0;

    function automatic void model_outs(input int fwd_en, output logic [47:0] d,
                                       output logic [5:0] s, output logic st);
        logic stall_any;
        stall_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic req, xh, mh;
            logic [2:0] r;
            req = src_req[i] && ex_valid;
            r   = src_reg[i*3 +: 3];
            xh  = req && xm_valid && xm_wr_en && (r == xm_rd);
            mh  = req && mw_valid && mw_wr_en && (r == mw_rd);
            d[i*16 +: 16] = src_data[i*16 +: 16];
            s[i*2 +: 2]   = 2'd0;
            if (fwd_en == 0) begin
                if (xh || mh) stall_any = 1'b1;
            end else begin
                if (m_cap_v[i]) begin
                    d[i*16 +: 16] = m_cap_d[i];
                    s[i*2 +: 2]   = 2'd3;
                end else if (xh && !xm_mem_read) begin
                    d[i*16 +: 16] = xm_data;
                    s[i*2 +: 2]   = 2'd1;
                end else if (mh) begin
                    d[i*16 +: 16] = mw_data;
                    s[i*2 +: 2]   = 2'd2;
                end
                if (xh && xm_mem_read && !m_cap_v[i]) stall_any = 1'b1;
            end
        end
        st = stall_any && !flush;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [47:0] d1, d0;
        logic [5:0]  s1, s0;
        logic        t1, t0;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cap_v[i] = 1'b0;
                m_cap_d[i] = 16'h0;
            end
            m_cnt1 = 0;
            m_cnt0 = 0;
        end else begin
            model_outs(1, d1, s1, t1);
            model_outs(0, d0, s0, t0);
            if (t1 && m_cnt1 < 65535) m_cnt1++;
            if (t0 && m_cnt0 < 65535) m_cnt0++;
            if (flush || !ex_valid || (!t1 && !ext_stall)) begin
                for (int i = 0; i < 3; i++) m_cap_v[i] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!m_cap_v[i] && (s1[i*2 +: 2] == 2'd1 || s1[i*2 +: 2] == 2'd2)) begin
                        m_cap_v[i] = 1'b1;
                        m_cap_d[i] = d1[i*16 +: 16];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        logic [47:0] d1, d0;
        logic [5:0]  s1, s0;
        logic        t1, t0;
        model_outs(1, d1, s1, t1);
        model_outs(0, d0, s0, t0);
        chk({tag, " data1"}, fd1, d1);
        chk({tag, " sel1"},  {42'd0, fs1}, {42'd0, s1});
        chk({tag, " stall1"}, {47'd0, st1}, {47'd0, t1});
        chk({tag, " cnt1"},  {32'd0, sc1}, 48'(m_cnt1));
        chk({tag, " data0"}, fd0, d0);
        chk({tag, " sel0"},  {42'd0, fs0}, {42'd0, s0});
        chk({tag, " stall0"}, {47'd0, st0}, {47'd0, t0});
        chk({tag, " cnt0"},  {32'd0, sc0}, 48'(m_cnt0));
    endtask

    task automatic idle();
        ex_valid = 0; ext_stall = 0; flush = 0; src_req = 0; src_reg = 0;
        src_data = 48'h0C0C_0B0B_0A0A;
        xm_valid = 0; xm_wr_en = 0; xm_mem_read = 0; xm_rd = 0; xm_data = 0;
        mw_valid = 0; mw_wr_en = 0; mw_rd = 0; mw_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        ev, fl;
        logic [2:0]  req;
        logic [8:0]  regs;
        logic        xv, xw, xl;
        logic [2:0]  xrd;
        logic [15:0] xd;
        logic        mv;
        logic [2:0]  mrd;
        logic [15:0] md;
        logic [47:0] e_data;
        logic [5:0]  e_sel;
        logic        e_st1, e_st0;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mkv(logic ev, logic fl, logic [2:0] req, logic [8:0] regs,
                                 logic xv, logic xw, logic xl, logic [2:0] xrd, logic [15:0] xd,
                                 logic mv, logic [2:0] mrd, logic [15:0] md,
                                 logic [47:0] ed, logic [5:0] es, logic e1, logic e0);
        vec_t v;
        v.ev = ev; v.fl = fl; v.req = req; v.regs = regs;
        v.xv = xv; v.xw = xw; v.xl = xl; v.xrd = xrd; v.xd = xd;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.e_data = ed; v.e_sel = es; v.e_st1 = e1; v.e_st0 = e0;
        return v;
    endfunction

    initial begin
        localparam logic [47:0] SD = 48'h0C0C_0B0B_0A0A;
        vecs[0]  = mkv(1, 0, 3'b011, {3'd0, 3'd4, 3'd3}, 1, 1, 0, 3'd3, 16'h1234, 0, 3'd0, 16'h0,
                       48'h0C0C_0B0B_1234, 6'b000001, 0, 1);
        vecs[1]  = mkv(1, 0, 3'b001, {3'd0, 3'd0, 3'd3}, 1, 1, 0, 3'd3, 16'h1111, 1, 3'd3, 16'h2222,
                       48'h0C0C_0B0B_1111, 6'b000001, 0, 1);
        vecs[2]  = mkv(1, 0, 3'b001, {3'd0, 3'd0, 3'd3}, 1, 0, 0, 3'd3, 16'h1111, 1, 3'd3, 16'h2222,
                       48'h0C0C_0B0B_2222, 6'b000010, 0, 1);
        vecs[3]  = mkv(1, 0, 3'b010, {3'd0, 3'd5, 3'd0}, 1, 1, 1, 3'd5, 16'h9999, 0, 3'd0, 16'h0,
                       SD, 6'b000000, 1, 1);
        vecs[4]  = mkv(1, 0, 3'b000, {3'd0, 3'd5, 3'd0}, 1, 1, 1, 3'd5, 16'h9999, 0, 3'd0, 16'h0,
                       SD, 6'b000000, 0, 0);
        vecs[5]  = mkv(1, 1, 3'b010, {3'd0, 3'd5, 3'd0}, 1, 1, 1, 3'd5, 16'h9999, 0, 3'd0, 16'h0,
                       SD, 6'b000000, 0, 0);
        vecs[6]  = mkv(0, 0, 3'b001, {3'd0, 3'd0, 3'd3}, 1, 1, 0, 3'd3, 16'h1234, 0, 3'd0, 16'h0,
                       SD, 6'b000000, 0, 0);
        vecs[7]  = mkv(1, 0, 3'b100, {3'd0, 3'd0, 3'd0}, 0, 0, 0, 3'd0, 16'h0, 1, 3'd0, 16'h5A5A,
                       48'h5A5A_0B0B_0A0A, 6'b100000, 0, 1);
        vecs[8]  = mkv(1, 0, 3'b111, {3'd7, 3'd7, 3'd7}, 1, 1, 0, 3'd7, 16'h7777, 0, 3'd0, 16'h0,
                       48'h7777_7777_7777, 6'b010101, 0, 1);
        vecs[9]  = mkv(1, 0, 3'b001, {3'd0, 3'd0, 3'd2}, 1, 1, 1, 3'd2, 16'h9999, 1, 3'd2, 16'h2222,
                       48'h0C0C_0B0B_2222, 6'b000010, 1, 1);
        vecs[10] = mkv(1, 0, 3'b001, {3'd0, 3'd0, 3'd3}, 0, 1, 0, 3'd3, 16'h1234, 0, 3'd0, 16'h0,
                       SD, 6'b000000, 0, 0);

        rst = 1'b0;
        idle();
        #23;
        chk("reset cnt", {32'd0, sc1}, 48'd0);
        chk("reset sel", {42'd0, fs1}, 48'd0);
        chk("reset stall", {47'd0, st1}, 48'd0);
        do_reset();

        // Load-use: one stall cycle, then MW forwarding.
        @(negedge clk);
        ex_valid = 1; src_req = 3'b010; src_reg = {3'd0, 3'd5, 3'd0};
        xm_valid = 1; xm_wr_en = 1; xm_mem_read = 1; xm_rd = 3'd5; xm_data = 16'h9999;
        #1;
        chk("loaduse stall", {47'd0, st1}, 48'd1);
        chk("loaduse sel", {42'd0, fs1}, 48'd0);
        check_model("loaduse a");
        @(negedge clk);
        xm_valid = 0; mw_valid = 1; mw_wr_en = 1; mw_rd = 3'd5; mw_data = 16'hBEEF;
        #1;
        chk("loaduse stall off", {47'd0, st1}, 48'd0);
        chk("loaduse data1", {32'd0, fd1[31:16]}, 48'hBEEF);
        chk("loaduse sel1", {46'd0, fs1[3:2]}, 48'd2);
        chk("loaduse cnt", {32'd0, sc1}, 48'd1);
        check_model("loaduse b");

        // Capture across ext_stall while MW drains.
        @(negedge clk);
        idle();
        ex_valid = 1; ext_stall = 1; src_req = 3'b001; src_reg = {3'd0, 3'd0, 3'd2};
        mw_valid = 1; mw_wr_en = 1; mw_rd = 3'd2; mw_data = 16'hAAAA;
        #1;
        chk("cap hit sel", {46'd0, fs1[1:0]}, 48'd2);
        chk("cap hit data", {32'd0, fd1[15:0]}, 48'hAAAA);
        check_model("cap a");
        @(negedge clk);
        mw_valid = 0;
        #1;
        chk("cap held sel", {46'd0, fs1[1:0]}, 48'd3);
        chk("cap held data", {32'd0, fd1[15:0]}, 48'hAAAA);
        check_model("cap b");
        @(negedge clk);
        ext_stall = 0;
        #1;
        chk("cap adv sel", {46'd0, fs1[1:0]}, 48'd3);
        check_model("cap c");
        @(negedge clk);
        #1;
        chk("cap clr sel", {46'd0, fs1[1:0]}, 48'd0);
        chk("cap clr data", {32'd0, fd1[15:0]}, 48'h0A0A);
        check_model("cap d");

        // Flush during a load-use hazard drops the stall and the captures.
        @(negedge clk);
        ext_stall = 1; mw_valid = 1;
        #1;
        check_model("flush a");
        @(negedge clk);
        mw_valid = 0; flush = 1; src_req = 3'b011; src_reg = {3'd0, 3'd5, 3'd2};
        xm_valid = 1; xm_wr_en = 1; xm_mem_read = 1; xm_rd = 3'd5;
        #1;
        chk("flush stall", {47'd0, st1}, 48'd0);
        chk("flush pre sel", {46'd0, fs1[1:0]}, 48'd3);
        check_model("flush b");
        @(negedge clk);
        flush = 0; xm_valid = 0;
        #1;
        chk("flush cleared sel", {46'd0, fs1[1:0]}, 48'd0);
        check_model("flush c");

        // Interlock-only instance: MW hit stalls without bypass.
        @(negedge clk);
        idle();
        ex_valid = 1; src_req = 3'b100; src_reg = {3'd6, 3'd0, 3'd0};
        mw_valid = 1; mw_wr_en = 1; mw_rd = 3'd6; mw_data = 16'h6666;
        #1;
        chk("nofwd stall", {47'd0, st0}, 48'd1);
        chk("nofwd sel", {42'd0, fs0}, 48'd0);
        chk("nofwd data2", {32'd0, fd0[47:32]}, 48'h0C0C);
        check_model("nofwd");

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            idle();
            ex_valid = vecs[v].ev; flush = vecs[v].fl; src_req = vecs[v].req; src_reg = vecs[v].regs;
            xm_valid = vecs[v].xv; xm_wr_en = vecs[v].xw; xm_mem_read = vecs[v].xl;
            xm_rd = vecs[v].xrd; xm_data = vecs[v].xd;
            mw_valid = vecs[v].mv; mw_wr_en = vecs[v].mv; mw_rd = vecs[v].mrd; mw_data = vecs[v].md;
            #1;
            chk($sformatf("vec%0d data", v), fd1, vecs[v].e_data);
            chk($sformatf("vec%0d sel", v), {42'd0, fs1}, {42'd0, vecs[v].e_sel});
            chk($sformatf("vec%0d stall1", v), {47'd0, st1}, {47'd0, vecs[v].e_st1});
            chk($sformatf("vec%0d stall0", v), {47'd0, st0}, {47'd0, vecs[v].e_st0});
            check_model($sformatf("vec%0d", v));
            @(negedge clk);
            idle();
        end

        // Reset asserted mid-hold with a live capture and stall_cnt=7.
        do_reset();
        @(negedge clk);
        ex_valid = 1; src_req = 3'b010; src_reg = {3'd0, 3'd5, 3'd2};
        xm_valid = 1; xm_wr_en = 1; xm_mem_read = 1; xm_rd = 3'd5;
        repeat (7) begin
            @(negedge clk);
        end
        xm_valid = 0; ext_stall = 1; src_req = 3'b001;
        mw_valid = 1; mw_wr_en = 1; mw_rd = 3'd2; mw_data = 16'hAAAA;
        @(negedge clk);
        mw_valid = 0;
        #1;
        chk("rsthold cnt", {32'd0, sc1}, 48'd7);
        chk("rsthold sel", {46'd0, fs1[1:0]}, 48'd3);
        check_model("rsthold");
        #1;
        rst = 1'b0;
        #1;
        chk("rst async cnt", {32'd0, sc1}, 48'd0);
        chk("rst async sel", {46'd0, fs1[1:0]}, 48'd0);
        chk("rst async data", {32'd0, fd1[15:0]}, 48'h0A0A);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            ex_valid    = ($urandom % 8) != 0;
            ext_stall   = ($urandom % 4) == 0;
            flush       = ($urandom % 10) == 0;
            src_req     = 3'($urandom);
            src_reg     = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            src_data    = {16'($urandom), 16'($urandom), 16'($urandom)};
            xm_valid    = ($urandom % 4) != 0;
            xm_wr_en    = ($urandom % 5) != 0;
            xm_mem_read = ($urandom % 3) == 0;
            xm_rd       = 3'($urandom_range(0, 3));
            xm_data     = 16'($urandom);
            mw_valid    = ($urandom % 4) != 0;
            mw_wr_en    = ($urandom % 5) != 0;
            mw_rd       = 3'($urandom_range(0, 3));
            mw_data     = 16'($urandom);
            #1;
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised operand-forwarding and load-use interlock unit for the EX stage of the 5-stage pipeline. It serves NSRC source operands per EX instruction and bypasses from XM and MW, with XM taking priority. Values forwarded while EX is held are captured in per-source operand latches, so they survive the producer draining out of MW. It also counts hazard-stall cycles. A mode parameter selects full bypass or interlock-only operation.

Parameters:
DATA_W, 16, operand/data width
REG_W, 3, register specifier width
NSRC, 3, number of EX source operands (e.g. Rs, Rt, store data)
FWD_EN, 1, 1 = bypass + load-use stall; 0 = no bypass, stall on any RAW against XM or MW
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX holds a real instruction
ext_stall  in  1  pipeline-wide freeze from memory/downstream; EX holds
flush  in  1  EX instruction squashed this cycle
src_req  in  NSRC  source i is actually read by the EX instruction
src_reg  in  NSRC*REG_W  source specifiers, source i at [i*REG_W +: REG_W]
src_data  in  NSRC*DATA_W  register-file values latched in DX
xm_valid, xm_wr_en, xm_mem_read  in  1 each  XM writer qualifiers (mem_read marks a load)
xm_rd  in  REG_W  XM destination
xm_data  in  DATA_W  XM ALU result
mw_valid, mw_wr_en  in  1 each  MW writer qualifiers
mw_rd  in  REG_W  MW destination
mw_data  in  DATA_W  final writeback value
fwd_data  out  NSRC*DATA_W  resolved operand per source
fwd_sel  out  NSRC*2  per source: 0 regfile, 1 XM, 2 MW, 3 captured
stall_ex  out  1  hazard stall request (hold DX/EX, bubble into XM)
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Hit definitions for source i (req_i = src_req[i] & ex_valid):
  - xm_hit_i = req_i & xm_valid & xm_wr_en & (src_reg_i == xm_rd)
  - mw_hit_i = req_i & mw_valid & mw_wr_en & (src_reg_i == mw_rd)
  - No register is hardwired to zero; r0 is forwarded like any other register.
- Operand select with FWD_EN=1, highest priority first:
  - cap_valid_i -> cap_data_i, sel 3
  - xm_hit_i & ~xm_mem_read -> xm_data, sel 1
  - mw_hit_i -> mw_data, sel 2
  - otherwise src_data_i, sel 0
- Stall with FWD_EN=1: stall_ex = OR over i of (xm_hit_i & xm_mem_read & ~cap_valid_i). A load-use hazard costs exactly 1 stall cycle; the next cycle the load sits in MW and is forwarded with sel 2.
- FWD_EN=0:
  - fwd_data_i = src_data_i and sel 0 always; the capture latches are never set.
  - stall_ex = OR over i of (xm_hit_i | mw_hit_i). Register-file write-before-read covers the rest.
- stall_ex is combinational and is 0 whenever ex_valid=0 or flush=1.
- Definitions: hold = ex_valid & (stall_ex | ext_stall) & ~flush; advance = ex_valid & ~stall_ex & ~ext_stall.
- Capture: on a clock edge with hold=1 and FWD_EN=1, every source with sel 1 or 2 and cap_valid_i=0 sets cap_valid_i=1 and cap_data_i = its current fwd_data_i.
- Once set, a capture is never overwritten while holding. During a hold only bubbles enter XM behind EX, so any later hit comes from an older producer and is stale.
- cap_valid is cleared on any edge with advance=1, flush=1 or ex_valid=0. Flush has priority over capture.
- stall_cnt increments by 1 on each edge with stall_ex=1, regardless of ext_stall, and saturates at all-ones. It is cleared only by reset.
- Reset (async assert, any time, including mid-hold): cap_valid=0, cap_data=0, stall_cnt=0. Outputs then follow the combinational rules: sel 0 and stall_ex=0 when ex_valid=0.
- Simultaneous XM and MW hit on the same register: XM wins (younger producer). If XM is a load, stall, even when MW also matches.
- Multiple sources naming the same register resolve independently and identically.

Test Plan:
- ALU bypass: XM non-load rd=3 data 0x1234; src0 reg 3 req -> fwd_data0=0x1234, sel0=1, stall_ex=0; src1 reg 4 -> sel 0, src_data.
- Priority: XM rd=3 0x1111 and MW rd=3 0x2222 -> 0x1111 sel 1; with xm_wr_en=0 -> 0x2222 sel 2.
- Load-use: XM load rd=5, src1 reg 5 -> stall_ex=1 for exactly 1 cycle; next cycle MW rd=5 0xBEEF -> fwd_data1=0xBEEF sel 2, stall_ex=0; stall_cnt=1.
- Capture: ext_stall=1, MW rd=2 0xAAAA hits src0 -> next cycle MW bubble: src0 still 0xAAAA sel 3; ext_stall=0 advances -> next cycle cap_valid cleared, sel 0.
- Masking and flush: src_req=0 with an XM load match -> no stall, sel 0; flush=1 during a load-use hazard -> stall_ex=0, captures cleared.
- Reset mid-hold: assert rst=0 with cap_valid set and stall_cnt=7 -> immediately cap_valid=0, stall_cnt=0. Separately, a FWD_EN=0 instance with MW rd=6 hitting src2 -> stall_ex=1, sel 0.
